i2c_apb_arbiter: RTL and testbench

- Shares the single APB slave port of the I2C master/slave controller among NUM_REQ on-chip requesters, e.g. a CPU bridge, a DMA engine and a testbench sequencer.
- Performs round-robin arbitration and drives standard two-phase APB transfers (SETUP, then ACCESS) on the pclk domain.
- Returns read data, completion and error status to the requester that was granted.
- A programmable timeout aborts a transfer whose pready never arrives.

---
 rtl/i2c_apb_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_i2c_apb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_apb_arbiter.sv
// Round-robin arbiter sharing the I2C controller's single APB slave port among NUM_REQ requesters.
// Optional: define I2C_ARB_LOCK_EN to add req_lock, which lets a requester keep priority across transfers.
module i2c_apb_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef I2C_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;

  logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]    wdata_arr [NUM_REQ];
  logic                 found;
  logic [IDX_W-1:0]     win, cand;
  logic                 keep_ptr;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

`ifdef I2C_ARB_LOCK_EN
  assign keep_ptr = req_lock[gidx_q];
`else
  assign keep_ptr = 1'b0;
`endif

  // First requesting index at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwdata_d  = pwdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = SETUP;
          gidx_d      = win;
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          paddr_d     = addr_arr[win];
          pwrite_d    = req_write[win];
          pwdata_d    = wdata_arr[win];
          psel_d      = 1'b1;
          penable_d   = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (pready) begin
          state_d   = DONE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = gnt_q;
          err_d     = 1'b0;
          if (!pwrite_q) rdata_d = prdata;
        end else if (TIMEOUT_CYC != 0 && cnt_q == CNT_LAST) begin
          state_d   = DONE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = gnt_q;
          err_d     = 1'b1;
          rdata_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        if (keep_ptr)                ptr_d = gidx_q;
        else if (gidx_q == IDX_LAST) ptr_d = '0;
        else                         ptr_d = gidx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign gnt_o   = gnt_q;
  assign paddr   = paddr_q;
  assign pwrite  = pwrite_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// Randomized bench for i2c_apb_arbiter: transaction-level round-robin model with cycle-exact timing checks.
module tb_i2c_apb_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 8;

  logic            pclk = 1'b0;
  logic            preset = 1'b0;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    done_o, gnt_o;
  logic [DW-1:0]   rdata_o, pwdata, prdata;
  logic            err_o, pwrite, psel, penable, pready;
  logic [AW-1:0]   paddr;
`ifdef I2C_ARB_LOCK_EN
  logic [N-1:0]    req_lock;
`endif

  i2c_apb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef I2C_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o), .gnt_o(gnt_o),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // Requester-side view: who is asking, what they ask for, and where the fairness pointer sits.
  bit            pend   [N];
  bit            m_wr   [N];
  bit            m_lock [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  int            ptr = 0;
  logic [DW-1:0] exp_rdata = '0;
  bit            keep = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend[i];
      req_write[i]          = m_wr[i];
      req_addr[i*AW +: AW]  = m_addr[i];
      req_wdata[i*DW +: DW] = m_data[i];
`ifdef I2C_ARB_LOCK_EN
      req_lock[i]           = m_lock[i];
`endif
    end
  endtask

  task automatic new_req(input int i);
    pend[i]   = 1'b1;
    m_wr[i]   = 1'($urandom_range(0, 1));
    m_addr[i] = AW'($urandom);
    m_data[i] = DW'($urandom);
  endtask

  task automatic do_reset();
    preset = 1'b0;
    step();
    check("rst_done", 32'(done_o), 32'(0));
    check("rst_gnt", 32'(gnt_o), 32'(0));
    check("rst_psel_pen", 32'({psel, penable}), 32'(0));
    check("rst_err_rdata", 32'({err_o, rdata_o}), 32'(0));
    check("rst_apb", 32'({paddr, pwrite, pwdata}), 32'(0));
    preset    = 1'b1;
    ptr       = 0;
    exp_rdata = '0;
  endtask

  // One whole transfer: w = ACCESS wait cycles before pready (w >= TO means pready never comes).
  task automatic do_xfer(input int w, input logic [DW-1:0] rd);
    int win;
    bit tout;
    win = -1;
    for (int j = 0; j < N; j++)
      if (win < 0 && pend[(ptr + j) % N]) win = (ptr + j) % N;
    if (win < 0) begin
      new_req(ptr);
      apply();
      win = ptr;
    end
    tout = (w >= TO);
    step();
    check("setup_psel_pen", 32'({psel, penable}), 32'(2));
    check("setup_gnt", 32'(gnt_o), 32'(onehot(win)));
    check("setup_paddr", 32'(paddr), 32'(m_addr[win]));
    check("setup_pwrite", 32'(pwrite), 32'(m_wr[win]));
    check("setup_pwdata", 32'(pwdata), 32'(m_data[win]));
    check("setup_done", 32'(done_o), 32'(0));
    pready = 1'($urandom_range(0, 1));
    prdata = DW'($urandom);
    step();
    pready = 1'b0;
    for (int k = 0; k < TO + 4; k++) begin
      check("access_psel_pen", 32'({psel, penable}), 32'(3));
      check("access_done", 32'(done_o), 32'(0));
      check("access_paddr", 32'(paddr), 32'(m_addr[win]));
      pready = (k == w);
      prdata = (k == w) ? rd : DW'($urandom);
      step();
      pready = 1'b0;
      if (k == w || (tout && k == TO - 1)) break;
    end
    if (tout) exp_rdata = '0;
    else if (!m_wr[win]) exp_rdata = rd;
    check("done_vec", 32'(done_o), 32'(onehot(win)));
    check("done_err", 32'(err_o), 32'(tout));
    check("done_rdata", 32'(rdata_o), 32'(exp_rdata));
    check("done_psel_pen", 32'({psel, penable}), 32'(0));
    $display("xfer req=%0d wr=%0d addr=%02h wdata=%02h waits=%0d err=%0b rdata=%02h",
             win, m_wr[win], m_addr[win], m_data[win], w, err_o, rdata_o);
    ptr = m_lock[win] ? win : (win + 1) % N;
    if (keep) new_req(win);
    else pend[win] = 1'b0;
    apply();
    step();
    check("idle_gnt", 32'(gnt_o), 32'(0));
    check("idle_done_psel", 32'({done_o, psel}), 32'(0));
  endtask

  initial begin
    pready = 1'b0;
    prdata = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; m_wr[i] = 1'b0; m_lock[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
    end
    apply();
    step();
    do_reset();

    // Directed: single write, then a read with three wait states.
    pend[0] = 1'b1; m_wr[0] = 1'b1; m_addr[0] = 8'h02; m_data[0] = 8'hA5;
    apply();
    do_xfer(0, 8'h00);
    pend[2] = 1'b1; m_wr[2] = 1'b0; m_addr[2] = 8'h05; m_data[2] = 8'h00;
    apply();
    do_xfer(3, 8'h3C);

    // Fairness: all requesters continuously valid from reset.
    do_reset();
    keep = 1'b1;
    for (int i = 0; i < N; i++) new_req(i);
    apply();
    for (int t = 0; t < 5; t++) do_xfer(0, DW'($urandom));
    keep = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;

    // Timeout and its boundary.
    new_req(1); m_wr[1] = 1'b0;
    apply();
    do_xfer(TO, 8'hFF);
    new_req(3); m_wr[3] = 1'b0;
    apply();
    do_xfer(TO - 1, 8'h5A);

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      keep = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i);
      if (!(pend[0] | pend[1] | pend[2] | pend[3])) new_req($urandom_range(0, N - 1));
      apply();
      do_xfer($urandom_range(0, TO + 2), DW'($urandom));
    end
    keep = 1'b0;

    // Reset during ACCESS: transfer dropped, pointer back to 0.
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    new_req(1); new_req(3);
    apply();
    step();
    check("mid_setup_psel", 32'(psel), 32'(1));
    step();
    check("mid_access_pen", 32'(penable), 32'(1));
    preset = 1'b0;
    step();
    check("mid_rst_psel_pen", 32'({psel, penable}), 32'(0));
    check("mid_rst_gnt_done", 32'({gnt_o, done_o}), 32'(0));
    preset = 1'b1; ptr = 0; exp_rdata = '0;
    do_xfer(0, DW'($urandom));
    do_xfer(1, DW'($urandom));

`ifdef I2C_ARB_LOCK_EN
    // Lock: requester 1 keeps the grant for three transfers while 0 and 2 wait.
    do_reset();
    new_req(1); m_lock[1] = 1'b1;
    pend[0] = 1'b0; pend[2] = 1'b0; pend[3] = 1'b0;
    apply();
    keep = 1'b1;
    do_xfer(0, DW'($urandom));
    new_req(0); new_req(2);
    apply();
    do_xfer(0, DW'($urandom));
    m_lock[1] = 1'b0;
    apply();
    do_xfer(0, DW'($urandom));
    keep = 1'b0;
    pend[1] = 1'b0;
    apply();
    do_xfer(0, DW'($urandom));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
